lif_neuron_array: RTL and testbench

Parametrised array of NUM_CH leaky integrate-and-fire (LIF) neurons. It succeeds the single fixed-width 8-bit membrane block.
- Each channel integrates its own synaptic input, applies a shift-based leak, fires a one-cycle spike when the threshold is crossed, and then enters an optional refractory period.
- The array sits between the input switch/bus decode and the seven-segment/GPIO output logic.
- It also exposes a global spike counter for observation.

---
 rtl/lif_neuron_array_if.sv | 24 ++
 rtl/lif_neuron_array.sv | 119 +++++++++++
 tb/tb_lif_neuron_array.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/lif_neuron_array_if.sv
// Bus bundle for lif_neuron_array: tick strobe, synaptic inputs and threshold
// in; membrane potentials, spikes, refractory flags and spike count out.
interface lif_neuron_array_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 2
);
  logic                      tick;
  logic [NUM_CH*WIDTH-1:0]   i_syn;
  logic [WIDTH-1:0]          threshold;
  logic [NUM_CH*WIDTH-1:0]   v_mem;
  logic [NUM_CH-1:0]         spike;
  logic [NUM_CH-1:0]         refrac;
  logic [15:0]               spike_count;

  modport master (
    output tick, i_syn, threshold,
    input  v_mem, spike, refrac, spike_count
  );

  modport slave (
    input  tick, i_syn, threshold,
    output v_mem, spike, refrac, spike_count
  );
endinterface

// File: rtl/lif_neuron_array.sv
// Array of NUM_CH leaky integrate-and-fire neurons with a shared threshold
// and a global wrapping spike counter.
// Optional feature macro: LIF_REFRACTORY_EN (adds per-channel refractory FSM).
module lif_neuron_array #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned LEAK_SHIFT   = 2,
  parameter int unsigned REFRAC_TICKS = 3
) (
  input  logic               clk,
  input  logic               reset,
  lif_neuron_array_if.slave  bus
);

  logic [WIDTH-1:0]  v_q [NUM_CH];
  logic [WIDTH-1:0]  v_d [NUM_CH];
  logic [WIDTH-1:0]  v_n [NUM_CH];
  logic [NUM_CH-1:0] fire;
  logic [NUM_CH-1:0] spike_q, spike_d;
  logic [15:0]       count_q, count_d;

`ifdef LIF_REFRACTORY_EN
  typedef enum logic {ST_INTEGRATE, ST_REFRACTORY} state_t;
  state_t      state_q [NUM_CH];
  state_t      state_d [NUM_CH];
  logic [3:0]  rcnt_q  [NUM_CH];
  logic [3:0]  rcnt_d  [NUM_CH];
`endif

  // Per-channel leak + integrate in WIDTH+1 bits, saturate, compare
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [WIDTH:0] sum;
    assign sum = {1'b0, v_q[k]} - {1'b0, (v_q[k] >> LEAK_SHIFT)}
               + {1'b0, bus.i_syn[k*WIDTH +: WIDTH]};
    assign v_n[k]  = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    assign fire[k] = (v_n[k] >= bus.threshold);
    assign bus.v_mem[k*WIDTH +: WIDTH] = v_q[k];
`ifdef LIF_REFRACTORY_EN
    assign bus.refrac[k] = (state_q[k] == ST_REFRACTORY);
`endif
  end

`ifndef LIF_REFRACTORY_EN
  // Always zero for any legal REFRAC_TICKS (1..15); no refractory logic is built
  assign bus.refrac = {NUM_CH{REFRAC_TICKS == 0}};
`endif

  assign bus.spike       = spike_q;
  assign bus.spike_count = count_q;

  // Next-state: integrate/fire (and refractory countdown), spike pulse, count
  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      v_d[k]     = v_q[k];
      spike_d[k] = 1'b0;
`ifdef LIF_REFRACTORY_EN
      state_d[k] = state_q[k];
      rcnt_d[k]  = rcnt_q[k];
`endif
    end
    count_d = count_q;

    if (bus.tick) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
`ifdef LIF_REFRACTORY_EN
        if (state_q[k] == ST_REFRACTORY) begin
          v_d[k]    = '0;
          rcnt_d[k] = rcnt_q[k] - 4'd1;
          if (rcnt_q[k] == 4'd1) state_d[k] = ST_INTEGRATE;
        end else if (fire[k]) begin
          spike_d[k] = 1'b1;
          v_d[k]     = '0;
          rcnt_d[k]  = 4'(REFRAC_TICKS);
          state_d[k] = ST_REFRACTORY;
        end else begin
          v_d[k] = v_n[k];
        end
`else
        if (fire[k]) begin
          spike_d[k] = 1'b1;
          v_d[k]     = '0;
        end else begin
          v_d[k] = v_n[k];
        end
`endif
      end
    end

    for (int unsigned k = 0; k < NUM_CH; k++) begin
      count_d = count_d + 16'(spike_d[k]);
    end
  end

  // State registers with synchronous reset taking priority over tick
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        v_q[k] <= '0;
`ifdef LIF_REFRACTORY_EN
        state_q[k] <= ST_INTEGRATE;
        rcnt_q[k]  <= '0;
`endif
      end
      spike_q <= '0;
      count_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        v_q[k] <= v_d[k];
`ifdef LIF_REFRACTORY_EN
        state_q[k] <= state_d[k];
        rcnt_q[k]  <= rcnt_d[k];
`endif
      end
      spike_q <= spike_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed self-checking bench for lif_neuron_array (WIDTH=8, NUM_CH=2,
// LEAK_SHIFT=2, REFRAC_TICKS=3). Expected values are hand-computed.
module tb_lif_neuron_array;

  logic clk;
  logic reset;
  int unsigned n_checks;
  int unsigned n_errors;

  lif_neuron_array_if #(.WIDTH(8), .NUM_CH(2)) bus ();

  lif_neuron_array #(
    .WIDTH(8), .NUM_CH(2), .LEAK_SHIFT(2), .REFRAC_TICKS(3)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset held with tick and saturated inputs
    reset = 1'b1;
    bus.tick = 1'b1;
    bus.i_syn = 16'hFFFF;
    bus.threshold = 8'd200;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("rst_vmem",  32'(bus.v_mem), 32'h0);
      check_val("rst_spike", 32'(bus.spike), 32'h0);
      check_val("rst_count", 32'(bus.spike_count), 32'h0);
      check_val("rst_refrac", 32'(bus.refrac), 32'h0);
    end

    // Integrate and fire: ch0=100, ch1=0, threshold 200
    reset = 1'b0;
    bus.i_syn = {8'd0, 8'd100};
    step();
    check_val("int_t1_v0", 32'(bus.v_mem[7:0]), 32'd100);
    step();
    check_val("int_t2_v0", 32'(bus.v_mem[7:0]), 32'd175);
    check_val("int_t2_spk", 32'(bus.spike), 32'h0);
    step();  // 175-43+100 = 232 >= 200
    check_val("int_t3_spk", 32'(bus.spike), 32'h1);
    check_val("int_t3_v0", 32'(bus.v_mem[7:0]), 32'd0);
    check_val("int_t3_cnt", 32'(bus.spike_count), 32'd1);
    check_val("int_t3_v1", 32'(bus.v_mem[15:8]), 32'd0);
`ifdef LIF_REFRACTORY_EN
    check_val("ref_rise", 32'(bus.refrac), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("ref_v0", 32'(bus.v_mem[7:0]), 32'd0);
      check_val("ref_spk", 32'(bus.spike), 32'h0);
      check_val("ref_flag", 32'(bus.refrac), (i < 2) ? 32'h1 : 32'h0);
    end
    step();
    check_val("ref_after_v0", 32'(bus.v_mem[7:0]), 32'd100);
`else
    check_val("norefrac_flag", 32'(bus.refrac), 32'h0);
    step();
    check_val("post_spk_v0", 32'(bus.v_mem[7:0]), 32'd100);
    check_val("post_spk_pulse", 32'(bus.spike), 32'h0);
    check_val("post_spk_cnt", 32'(bus.spike_count), 32'd1);
`endif

    // Tick gating: inputs change but nothing advances
    bus.tick = 1'b0;
    bus.i_syn = {8'd50, 8'd9};
    bus.threshold = 8'd0;
    for (int i = 0; i < 10; i++) step();
    check_val("gate_v0", 32'(bus.v_mem[7:0]), 32'd100);
    check_val("gate_v1", 32'(bus.v_mem[15:8]), 32'd0);
    check_val("gate_spk", 32'(bus.spike), 32'h0);
    check_val("gate_cnt", 32'(bus.spike_count), 32'd1);
    bus.tick = 1'b1;
    bus.i_syn = {8'd0, 8'd100};
    bus.threshold = 8'd200;
    step();
    check_val("gate_resume_v0", 32'(bus.v_mem[7:0]), 32'd175);

    // Saturation: V0=200 then +255 with threshold 255
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.threshold = 8'd255;
    bus.i_syn = {8'd0, 8'd200};
    step();
    check_val("sat_pre_v0", 32'(bus.v_mem[7:0]), 32'd200);
    bus.i_syn = {8'd0, 8'd255};
    step();  // 200-50+255 = 405 -> clamp 255
    check_val("sat_spk", 32'(bus.spike), 32'h1);
    check_val("sat_v0", 32'(bus.v_mem[7:0]), 32'd0);
    check_val("sat_cnt", 32'(bus.spike_count), 32'd1);
`ifdef LIF_REFRACTORY_EN
    check_val("sat_refrac", 32'(bus.refrac), 32'h1);
`endif

    // Reset while (possibly) refractory clears everything at once
    reset = 1'b1;
    step();
    check_val("midrst_refrac", 32'(bus.refrac), 32'h0);
    check_val("midrst_cnt", 32'(bus.spike_count), 32'h0);
    check_val("midrst_v0", 32'(bus.v_mem[7:0]), 32'h0);
    reset = 1'b0;

    // Just below saturation does not fire at threshold 255
    bus.i_syn = {8'd0, 8'd254};
    step();
    check_val("thrmax_v0", 32'(bus.v_mem[7:0]), 32'd254);
    check_val("thrmax_spk", 32'(bus.spike), 32'h0);

    // threshold=0: both channels fire on every tick
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.threshold = 8'd0;
    bus.i_syn = {8'd5, 8'd7};
    step();
    check_val("both_t1_spk", 32'(bus.spike), 32'h3);
    check_val("both_t1_cnt", 32'(bus.spike_count), 32'd2);
`ifdef LIF_REFRACTORY_EN
    step();
    check_val("both_t2_spk", 32'(bus.spike), 32'h0);
    check_val("both_t2_ref", 32'(bus.refrac), 32'h3);
    check_val("both_t2_cnt", 32'(bus.spike_count), 32'd2);
`else
    step();
    check_val("both_t2_spk", 32'(bus.spike), 32'h3);
    check_val("both_t2_cnt", 32'(bus.spike_count), 32'd4);
    step();
    check_val("both_t3_cnt", 32'(bus.spike_count), 32'd6);
    check_val("both_t3_v", 32'(bus.v_mem), 32'h0);
    bus.tick = 1'b0;
    step();
    check_val("both_idle_spk", 32'(bus.spike), 32'h0);
    check_val("both_idle_cnt", 32'(bus.spike_count), 32'd6);

    // Counter wrap: 32767 double ticks, then single spikes
    reset = 1'b1;
    bus.tick = 1'b1;
    step();
    reset = 1'b0;
    bus.i_syn = 16'h0000;
    bus.threshold = 8'd0;
    for (int i = 0; i < 32767; i++) step();
    check_val("wrap_pre_cnt", 32'(bus.spike_count), 32'hFFFE);
    bus.threshold = 8'd200;
    bus.i_syn = {8'd0, 8'd255};
    step();
    check_val("wrap_ffff_cnt", 32'(bus.spike_count), 32'hFFFF);
    check_val("wrap_ffff_spk", 32'(bus.spike), 32'h1);
    step();
    check_val("wrap_zero_cnt", 32'(bus.spike_count), 32'h0000);
    check_val("wrap_zero_spk", 32'(bus.spike), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
